// File: rtl/seq_shift_sub_divider_if.sv
// seq_shift_sub_divider_if: start/busy/done handshake plus operand and result buses
// for the shift-subtract divider.
interface seq_shift_sub_divider_if #(
   parameter int BIT_WIDTH = 8
);
   logic                     start;
   logic [2*BIT_WIDTH-1:0]   dividend;
   logic [BIT_WIDTH-1:0]     divisor;
   logic [2*BIT_WIDTH-1:0]   quotient;
   logic [BIT_WIDTH-1:0]     remainder;
   logic                     busy;
   logic                     done;
   logic                     div_by_zero;
   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );
   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

// File: rtl/seq_shift_sub_divider.sv
// seq_shift_sub_divider: restoring shift-subtract divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement truncating division.
module seq_shift_sub_divider #(
   parameter int BIT_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   seq_shift_sub_divider_if.slave  bus
);
   localparam int W  = 2*BIT_WIDTH;
   localparam int CW = $clog2(W+1);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t               state;
   logic [BIT_WIDTH-1:0] prem;
   logic [W-1:0]         sreg;
   logic [BIT_WIDTH-1:0] dreg;
   logic [CW-1:0]        cnt;
   logic                 zero_div;
   logic                 dvs_zero;
   logic [BIT_WIDTH:0]   shifted;
   logic [BIT_WIDTH:0]   trial;
   logic [W-1:0]         dvd_mag;
   logic [BIT_WIDTH-1:0] dvs_mag;
   logic [W-1:0]         quo_out;
   logic [BIT_WIDTH-1:0] rem_out;
   assign dvs_zero = bus.divisor == '0;
   assign shifted  = {prem, sreg[W-1]};
   assign trial    = shifted - {1'b0, dreg};
`ifdef SEQ_DIVIDER_SIGNED_EN
   logic neg_q;
   logic neg_r;
   assign dvd_mag = bus.dividend[W-1] ? -bus.dividend : bus.dividend;
   assign dvs_mag = bus.divisor[BIT_WIDTH-1] ? -bus.divisor : bus.divisor;
   assign quo_out = neg_q ? -sreg : sreg;
   assign rem_out = neg_r ? -prem : prem;
`else
   assign dvd_mag = bus.dividend;
   assign dvs_mag = bus.divisor;
   assign quo_out = sreg;
   assign rem_out = prem;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         prem            <= '0;
         sreg            <= '0;
         dreg            <= '0;
         cnt             <= '0;
         zero_div        <= 1'b0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_q           <= 1'b0;
         neg_r           <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               // a zero divisor skips RUN, so keep the raw dividend for the remainder
               sreg            <= dvs_zero ? bus.dividend : dvd_mag;
               dreg            <= dvs_mag;
               prem            <= '0;
               cnt             <= CW'(W);
               zero_div        <= dvs_zero;
               bus.busy        <= 1'b1;
               bus.div_by_zero <= 1'b0;
               state           <= dvs_zero ? FIN : RUN;
`ifdef SEQ_DIVIDER_SIGNED_EN
               neg_q           <= bus.dividend[W-1] ^ bus.divisor[BIT_WIDTH-1];
               neg_r           <= bus.dividend[W-1];
`endif
            end
            RUN: begin
               prem  <= trial[BIT_WIDTH] ? shifted[BIT_WIDTH-1:0] : trial[BIT_WIDTH-1:0];
               sreg  <= {sreg[W-2:0], ~trial[BIT_WIDTH]};
               cnt   <= cnt - 1'b1;
               state <= (cnt == CW'(1)) ? FIN : RUN;
            end
            FIN: begin
               bus.quotient    <= zero_div ? '1 : quo_out;
               bus.remainder   <= zero_div ? sreg[BIT_WIDTH-1:0] : rem_out;
               bus.div_by_zero <= zero_div;
               bus.done        <= 1'b1;
               bus.busy        <= 1'b0;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_shift_sub_divider.sv
// tb_seq_shift_sub_divider: randomized and directed checks of the divider against
// an arithmetic reference model.
module tb_seq_shift_sub_divider;
   localparam int BW = 8;
   logic clk;
   logic rst_n;
   int   cmp;
   int   errs;
   seq_shift_sub_divider_if #(.BIT_WIDTH(BW)) bus ();
   seq_shift_sub_divider #(.BIT_WIDTH(BW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic void model(input logic [2*BW-1:0] a, input logic [BW-1:0] b,
                                 output logic [2*BW-1:0] q, output logic [BW-1:0] r,
                                 output logic z);
      int sa;
      int sb;
      if (b == '0) begin
         q = '1;
         r = a[BW-1:0];
         z = 1'b1;
      end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
         sa = int'($signed(a));
         sb = int'($signed(b));
         q  = (2*BW)'(sa / sb);
         r  = BW'(sa % sb);
`else
         sa = int'(a);
         sb = int'(b);
         q  = (2*BW)'(sa / sb);
         r  = BW'(sa % sb);
`endif
         z  = 1'b0;
      end
   endfunction
   task automatic issue(input logic [2*BW-1:0] a, input logic [BW-1:0] b);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start    = 1'b0;
   endtask
   task automatic wait_done(output int lat, output int bcnt);
      lat  = -1;
      bcnt = 0;
      for (int k = 1; k <= 40; k++) begin
         if (bus.busy) bcnt++;
         @(posedge clk); #1;
         if (bus.done) begin
            lat = k;
            break;
         end
      end
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      #12;
      cmp++;
      if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== '0) begin
         errs++;
         $display("FAIL reset_outputs got q=%h r=%h busy=%b done=%b dbz=%b want all 0",
                  bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask
   task automatic test_basic();
      int lat, bcnt;
      issue(16'd1000, 8'd7);
      cmp++;
      if (bus.busy !== 1'b1) begin
         errs++; $display("FAIL basic_busy_after_start got %b want 1", bus.busy);
      end
      wait_done(lat, bcnt);
      cmp++;
      if (lat !== 17 || bcnt !== 17) begin
         errs++; $display("FAIL basic_latency got lat=%0d busy_cycles=%0d want 17/17", lat, bcnt);
      end
      cmp++;
      if (bus.quotient !== 16'd142 || bus.remainder !== 8'd6 || bus.div_by_zero !== 1'b0) begin
         errs++;
         $display("FAIL basic_result got q=%0d r=%0d dbz=%b want 142 6 0",
                  bus.quotient, bus.remainder, bus.div_by_zero);
      end
      @(posedge clk); #1;
      cmp++;
      if (bus.done !== 1'b0 || bus.quotient !== 16'd142 || bus.remainder !== 8'd6) begin
         errs++;
         $display("FAIL basic_hold got done=%b q=%0d r=%0d want 0 142 6",
                  bus.done, bus.quotient, bus.remainder);
      end
   endtask
   task automatic test_boundary();
      logic [2*BW-1:0] av [3] = '{16'd65535, 16'd0, 16'd254};
      logic [BW-1:0]   bv [3] = '{8'd255, 8'd5, 8'd255};
      logic [2*BW-1:0] eq;
      logic [BW-1:0]   er;
      logic            ez;
      int lat, bcnt;
      for (int i = 0; i < 3; i++) begin
         model(av[i], bv[i], eq, er, ez);
         issue(av[i], bv[i]);
         wait_done(lat, bcnt);
         cmp++;
         if (lat !== 17 || bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== ez) begin
            errs++;
            $display("FAIL boundary_%0d/%0d got lat=%0d q=%0d r=%0d dbz=%b want lat=17 q=%0d r=%0d dbz=%b",
                     av[i], bv[i], lat, bus.quotient, bus.remainder, bus.div_by_zero, eq, er, ez);
         end
      end
   endtask
   task automatic test_div_zero();
      int lat, bcnt;
      issue(16'd1234, 8'd0);
      wait_done(lat, bcnt);
      cmp++;
      if (lat !== 1) begin
         errs++; $display("FAIL dbz_latency got %0d want 1", lat);
      end
      cmp++;
      if (bus.quotient !== 16'hFFFF || bus.remainder !== 8'hD2 || bus.div_by_zero !== 1'b1) begin
         errs++;
         $display("FAIL dbz_result got q=%h r=%h dbz=%b want ffff d2 1",
                  bus.quotient, bus.remainder, bus.div_by_zero);
      end
      @(posedge clk); #1;
      issue(16'd10, 8'd3);
      cmp++;
      if (bus.div_by_zero !== 1'b0) begin
         errs++; $display("FAIL dbz_clear_on_start got %b want 0", bus.div_by_zero);
      end
      wait_done(lat, bcnt);
      cmp++;
      if (bus.quotient !== 16'd3 || bus.remainder !== 8'd1 || bus.div_by_zero !== 1'b0) begin
         errs++;
         $display("FAIL dbz_followup got q=%0d r=%0d dbz=%b want 3 1 0",
                  bus.quotient, bus.remainder, bus.div_by_zero);
      end
   endtask
   task automatic test_back_to_back();
      logic [2*BW-1:0] eq;
      logic [BW-1:0]   er;
      logic            ez;
      int lat, bcnt;
      issue(16'd1000, 8'd7);
      bus.dividend = 16'd500;
      bus.divisor  = 8'd3;
      bus.start    = 1'b1;
      wait_done(lat, bcnt);
      model(16'd1000, 8'd7, eq, er, ez);
      cmp++;
      if (lat !== 17 || bus.quotient !== eq || bus.remainder !== er) begin
         errs++;
         $display("FAIL ignored_start got lat=%0d q=%0d r=%0d want 17 %0d %0d",
                  lat, bus.quotient, bus.remainder, eq, er);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      cmp++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         errs++; $display("FAIL b2b_accept got busy=%b done=%b want 1 0", bus.busy, bus.done);
      end
      wait_done(lat, bcnt);
      cmp++;
      if (lat !== 17 || bus.quotient !== 16'd166 || bus.remainder !== 8'd2) begin
         errs++;
         $display("FAIL b2b_result got lat=%0d q=%0d r=%0d want 17 166 2",
                  lat, bus.quotient, bus.remainder);
      end
   endtask
   task automatic test_reset_mid();
      int lat, bcnt;
      issue(16'd1000, 8'd7);
      wait_done(lat, bcnt);
      issue(16'd4321, 8'd13);
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      cmp++;
      if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== '0) begin
         errs++;
         $display("FAIL async_reset got q=%h r=%h busy=%b done=%b dbz=%b want all 0",
                  bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
      end
      #10 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cmp++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== '0) begin
         errs++;
         $display("FAIL post_reset_idle got done=%b busy=%b q=%h want 0 0 0",
                  bus.done, bus.busy, bus.quotient);
      end
      issue(16'd100, 8'd9);
      wait_done(lat, bcnt);
      cmp++;
      if (lat !== 17 || bus.quotient !== 16'd11 || bus.remainder !== 8'd1) begin
         errs++;
         $display("FAIL post_reset_op got lat=%0d q=%0d r=%0d want 17 11 1",
                  lat, bus.quotient, bus.remainder);
      end
   endtask
   task automatic test_random();
      logic [2*BW-1:0] a, eq;
      logic [BW-1:0]   b, er;
      logic            ez;
      int lat, bcnt, want_lat;
      for (int i = 0; i < 40; i++) begin
         a = (2*BW)'($urandom);
         b = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom);
         if (i == 0) begin a = 16'h8000; b = 8'hFF; end
         model(a, b, eq, er, ez);
         want_lat = ez ? 1 : 17;
         issue(a, b);
         wait_done(lat, bcnt);
         cmp++;
         if (lat !== want_lat || bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== ez) begin
            errs++;
            $display("FAIL random_%h/%h got lat=%0d q=%h r=%h dbz=%b want lat=%0d q=%h r=%h dbz=%b",
                     a, b, lat, bus.quotient, bus.remainder, bus.div_by_zero, want_lat, eq, er, ez);
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #0;
      end
   endtask
   initial begin
      cmp  = 0;
      errs = 0;
      test_reset();
      test_basic();
      test_boundary();
      test_div_zero();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule
